uart_core: RTL and testbench



---
 rtl/uart_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_core.sv
// uart_core: full-duplex 7-bit UART, even parity, 1 start / 1 stop bit.
// Transmitter and receiver are independent FSMs sharing one clock; every
// output comes straight from a flop.
module uart_core #(
    parameter int CLKS_PER_BIT = 521
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [6:0] datain_tx,
    output logic       tx_out,
    input  logic       rx_in,
    output logic [6:0] dataout_rx,
    output logic       parity_error_rx,
    output logic       parity_received
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    // Last count of a full bit period.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // Start confirmation lands half a bit after the synchronized falling edge;
    // one cycle goes to the IDLE->START transition, one to the decision edge.
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [6:0] d);
        return ^d;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q,   tx_cnt_d;
    logic [2:0]      tx_bit_q,   tx_bit_d;
    logic [6:0]      tx_shift_q, tx_shift_d;
    logic            tx_par_q,   tx_par_d;
    logic            tx_out_q,   tx_out_d;

    // TX next state; tx_out is derived from the current state and registered,
    // so the line follows the state by exactly one cycle.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_out_d   = 1'b1;
        case (tx_state_q)
            ST_IDLE: begin
                tx_out_d = 1'b1;
                tx_cnt_d = CNT_ZERO;
                tx_bit_d = 3'd0;
                if (tx_start) begin
                    tx_shift_d = datain_tx;
                    tx_par_d   = even_parity(datain_tx);
                    tx_state_d = ST_START;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                tx_out_d = 1'b0;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                tx_out_d = tx_shift_q[0];
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_shift_d = {1'b0, tx_shift_q[6:1]};
                    if (tx_bit_q == 3'd6) begin
                        tx_state_d = ST_PARITY;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                tx_out_d = tx_par_q;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                tx_out_d = 1'b1;
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_out_d   = 1'b1;
                tx_cnt_d   = CNT_ZERO;
                tx_state_d = ST_IDLE;
            end
        endcase
    end

    // TX state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 7'd0;
            tx_par_q   <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign tx_out = tx_out_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic            rx_meta_q,  rx_meta_d;
    logic            rx_sync_q,  rx_sync_d;
    state_e          rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q,   rx_cnt_d;
    logic [2:0]      rx_bit_q,   rx_bit_d;
    logic [6:0]      rx_shift_q, rx_shift_d;
    logic [6:0]      rx_data_q,  rx_data_d;
    logic            rx_perr_q,  rx_perr_d;
    logic            rx_par_q,   rx_par_d;

    // Two-stage synchronizer input for the asynchronous serial line.
    always_comb begin
        rx_meta_d = rx_in;
        rx_sync_d = rx_meta_q;
    end

    // RX next state: half-bit start check, then full-bit sampling; the STOP
    // state waits for a high line so a held break cannot retrigger.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_perr_d  = rx_perr_q;
        rx_par_d   = rx_par_q;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = CNT_ZERO;
                rx_bit_d = 3'd0;
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = CNT_ZERO;
                    if (!rx_sync_q) begin
                        rx_state_d = ST_DATA;
                    end else begin
                        rx_state_d = ST_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_shift_d = {rx_sync_q, rx_shift_q[6:1]};
                    if (rx_bit_q == 3'd6) begin
                        rx_state_d = ST_PARITY;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_data_d  = rx_shift_q;
                    rx_par_d   = rx_sync_q;
                    rx_perr_d  = rx_sync_q ^ even_parity(rx_shift_q);
                    rx_state_d = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q != BIT_LAST) begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end else if (rx_sync_q) begin
                    rx_cnt_d   = CNT_ZERO;
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_STOP;
                end
            end
            default: begin
                rx_cnt_d   = CNT_ZERO;
                rx_state_d = ST_IDLE;
            end
        endcase
    end

    // RX synchronizer, state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= CNT_ZERO;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 7'd0;
            rx_data_q  <= 7'd0;
            rx_perr_q  <= 1'b0;
            rx_par_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_perr_q  <= rx_perr_d;
            rx_par_q   <= rx_par_d;
        end
    end

    assign dataout_rx      = rx_data_q;
    assign parity_error_rx = rx_perr_q;
    assign parity_received = rx_par_q;

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: table-driven RX frames, TX waveform
// check with loopback, glitch rejection and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_core;

    localparam int CPB = 521;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [6:0] datain_tx;
    logic       tx_out;
    logic       rx_in;
    logic       rx_bb;
    logic       loop_en;
    logic [6:0] dataout_rx;
    logic       parity_error_rx;
    logic       parity_received;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] data;
        logic       par;
        logic [6:0] exp_data;
        logic       exp_perr;
        logic       exp_prx;
    } rx_vec_t;

    rx_vec_t vecs [6];

    always #50 clk = ~clk;

    assign rx_in = loop_en ? tx_out : rx_bb;

    uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_start       (tx_start),
        .datain_tx      (datain_tx),
        .tx_out         (tx_out),
        .rx_in          (rx_in),
        .dataout_rx     (dataout_rx),
        .parity_error_rx(parity_error_rx),
        .parity_received(parity_received)
    );

    // Reference: parity bit is 1 exactly when the data has an odd number of ones.
    function automatic logic model_parity(input logic [6:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rx(input string tag, input logic [6:0] d, input logic perr, input logic prx);
        chk({tag, "_data"}, {25'd0, dataout_rx}, {25'd0, d});
        chk({tag, "_perr"}, {31'd0, parity_error_rx}, {31'd0, perr});
        chk({tag, "_prx"},  {31'd0, parity_received}, {31'd0, prx});
    endtask

    // Drive start, 7 data bits LSB first and parity from the negedge, then
    // return the line high and leave 10 cycles into the stop bit.
    task automatic send_rx(input logic [6:0] d, input logic p);
        rx_bb = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            rx_bb = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_bb = p;
        repeat (CPB) @(negedge clk);
        rx_bb = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Start a TX frame and compare every cycle of tx_out against the expected
    // bit sequence; a mid-frame tx_start and datain change must be ignored.
    task automatic tx_frame_check(input logic [6:0] d);
        logic [9:0] exp_bits;
        int bad [10];
        exp_bits = {1'b1, model_parity(d), d, 1'b0};
        for (int k = 0; k < 10; k++) bad[k] = 0;
        @(negedge clk);
        datain_tx = d;
        tx_start  = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        for (int c = 1; c <= 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            if (tx_out !== exp_bits[(c - 1) / CPB]) bad[(c - 1) / CPB]++;
            if (c == 1000) begin
                tx_start  = 1'b1;
                datain_tx = ~d;
            end
            if (c == 1001) tx_start = 1'b0;
        end
        for (int k = 0; k < 10; k++)
            chk($sformatf("tx_bit%0d_bad_cycles", k), bad[k], 32'd0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #(9_000_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0] d;
        logic       p;
        rst_n     = 1'b0;
        tx_start  = 1'b0;
        datain_tx = 7'd0;
        rx_bb     = 1'b1;
        loop_en   = 1'b0;

        // Reset state, both during and after reset.
        repeat (5) @(negedge clk);
        chk("rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk_rx("rst_in", 7'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_tx_out", {31'd0, tx_out}, 32'd1);
        chk_rx("post_rst", 7'd0, 1'b0, 1'b0);

        // RX vector table: fixed cases first, then randomized frames.
        vecs[0] = '{7'b1011011, 1'b1, 7'b1011011, 1'b0, 1'b1};
        vecs[1] = '{7'b1110001, 1'b0, 7'b1110001, 1'b0, 1'b0};
        vecs[2] = '{7'b1011011, 1'b0, 7'b1011011, 1'b1, 1'b0};
        for (int i = 3; i < 6; i++) begin
            d = 7'($urandom);
            p = 1'($urandom);
            vecs[i] = '{d, p, d, (($countones(d) + p) % 2) != 0, p};
        end

        // Frames sent back to back with only the stop bit between them.
        for (int i = 0; i < 6; i++) begin
            send_rx(vecs[i].data, vecs[i].par);
            chk_rx($sformatf("rx_vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_prx);
            repeat (CPB - 10) @(negedge clk);
        end

        // Glitch: 100 low cycles must not change outputs.
        rx_bb = 1'b0;
        repeat (100) @(negedge clk);
        rx_bb = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk_rx("glitch_hold", vecs[5].exp_data, vecs[5].exp_perr, vecs[5].exp_prx);

        // A frame after the glitch proves the receiver went back to idle.
        d = 7'($urandom);
        p = model_parity(d);
        send_rx(d, p);
        chk_rx("after_glitch", d, 1'b0, p);
        repeat (CPB - 10) @(negedge clk);

        // TX waveform with loopback into the receiver.
        loop_en = 1'b1;
        tx_frame_check(7'h5B);
        chk_rx("loop_5b", 7'h5B, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        d = 7'($urandom);
        tx_frame_check(d);
        chk_rx("loop_rand", d, 1'b0, model_parity(d));
        @(negedge clk);
        loop_en = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during RX data bit 3 with a TX frame (all-zero data) in flight.
        datain_tx = 7'h00;
        tx_start  = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        d = 7'b1011011;
        rx_bb = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_bb = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_bb = d[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rx_bb = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_tx_out", {31'd0, tx_out}, 32'd1);
        chk_rx("midrst", 7'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("midrst_tx_idle", {31'd0, tx_out}, 32'd1);
        d = 7'b0100110;
        p = model_parity(d);
        send_rx(d, p);
        chk_rx("after_midrst", d, 1'b0, p);
        repeat (CPB - 10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
